// File: rtl/rename_ctrl.sv
// Rename controller: hands out physical registers to the decoder and recycles
// registers freed at commit through a small two-lane return FIFO.
module rename_ctrl #(
  parameter int NUM_FREE  = 31,
  parameter int RET_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic       dec_wr,
  input  logic [4:0] dec_dest,
  output logic       dec_ready,
  input  logic [1:0] rob_ret_valid,
  input  logic [9:0] rob_ret_preg,
  output logic       rob_ret_ready,
  output logic       ren_assign_flag,
  output logic       ren_commit_flag,
  output logic [4:0] ren_commit_phys,
  output logic       rename_valid,
  output logic [5:0] free_count,
  output logic       err_overflow
);

  localparam int PW = $clog2(RET_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_STALL, S_ERROR} state_t;

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_fifo [RET_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr, w_wr_ptr1;
  logic [CW-1:0]   r_occ, w_push_n;
  logic [5:0]      r_free_cnt;
  logic            r_err, r_ren_vld;
  logic [1:0]      w_push;
  logic            w_alloc_req, w_accept, w_alloc;
  logic            w_active, w_pop_try, w_ovf, w_pop;

  assign w_alloc_req = dec_wr && (dec_dest != 5'd0);
  assign w_accept    = dec_valid && dec_ready;
  assign w_alloc     = w_accept && w_alloc_req;
  assign w_active    = (r_state == S_RUN) || (r_state == S_STALL);
  // Pop only from entries already stored, so a return is never reused in its own cycle.
  assign w_pop_try   = w_active && (r_occ != '0);
  assign w_ovf       = w_pop_try && (r_free_cnt == 6'(NUM_FREE));
  assign w_pop       = w_pop_try && !w_ovf;

  always_comb begin
    for (int i = 0; i < 2; i++)
      w_push[i] = rob_ret_ready && rob_ret_valid[i] && (rob_ret_preg[i*5 +: 5] != 5'd0);
  end

  assign w_push_n  = CW'(w_push[0]) + CW'(w_push[1]);
  assign w_wr_ptr1 = r_wr_ptr + PW'(w_push[0]);

  always_comb begin
    w_state_nxt   = r_state;
    dec_ready     = 1'b0;
    rob_ret_ready = 1'b0;
    case (r_state)
      S_INIT:  w_state_nxt = S_RUN;
      S_RUN: begin
        dec_ready     = (r_free_cnt != 6'd0) || !w_alloc_req;
        rob_ret_ready = r_occ <= CW'(RET_DEPTH - 2);
        if (dec_valid && w_alloc_req && r_free_cnt == 6'd0) w_state_nxt = S_STALL;
      end
      S_STALL: begin
        rob_ret_ready = r_occ <= CW'(RET_DEPTH - 2);
        if (r_free_cnt != 6'd0) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_ERROR;
    endcase
    if (w_ovf) w_state_nxt = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_free_cnt <= 6'(NUM_FREE);
      r_err      <= 1'b0;
      r_ren_vld  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ren_vld  <= w_accept;
      r_free_cnt <= r_free_cnt - 6'(w_alloc) + 6'(w_pop);
      r_wr_ptr   <= r_wr_ptr + PW'(w_push_n);
      r_rd_ptr   <= r_rd_ptr + PW'(w_pop);
      r_occ      <= r_occ + w_push_n - CW'(w_pop);
      if (w_ovf) r_err <= 1'b1;
    end
  end

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (w_push[0]) r_fifo[r_wr_ptr]  <= rob_ret_preg[4:0];
    if (w_push[1]) r_fifo[w_wr_ptr1] <= rob_ret_preg[9:5];
  end

  assign ren_assign_flag = w_alloc;
  assign ren_commit_flag = w_pop;
  assign ren_commit_phys = w_pop ? r_fifo[r_rd_ptr] : 5'd0;
  assign rename_valid    = r_ren_vld;
  assign free_count      = r_free_cnt;
  assign err_overflow    = r_err;

endmodule

// File: tb/tb_rename_ctrl.sv
// Bench for rename_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based model.
module tb_rename_ctrl;
  localparam int NF = 31;
  localparam int RD = 4;

  logic       clk = 1'b0, reset = 1'b1;
  logic       dec_valid = 1'b0, dec_wr = 1'b0;
  logic [4:0] dec_dest = 5'd0;
  logic [1:0] rob_ret_valid = 2'b00;
  logic [9:0] rob_ret_preg = 10'd0;
  logic       dec_ready, rob_ret_ready, ren_assign_flag, ren_commit_flag;
  logic [4:0] ren_commit_phys;
  logic       rename_valid, err_overflow;
  logic [5:0] free_count;

  rename_ctrl #(.NUM_FREE(NF), .RET_DEPTH(RD)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_wr(dec_wr),
    .dec_dest(dec_dest), .dec_ready(dec_ready), .rob_ret_valid(rob_ret_valid),
    .rob_ret_preg(rob_ret_preg), .rob_ret_ready(rob_ret_ready),
    .ren_assign_flag(ren_assign_flag), .ren_commit_flag(ren_commit_flag),
    .ren_commit_phys(ren_commit_phys), .rename_valid(rename_valid),
    .free_count(free_count), .err_overflow(err_overflow));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  function automatic void chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", n, a, e, $time);
    end
  endfunction

  // Model: free registers as a count, returned registers as a queue, plus
  // flags for "first cycle after reset", "waiting for a register" and "dead".
  bit m_on = 0, m_init, m_err, m_stall, m_rv;
  int m_free;
  int m_q[$];
  bit req, run, e_dr, e_rr, acc, alloc, ptry, ovf, pop;
  int e_ph, old_free;

  always @(negedge clk) begin
    req  = dec_wr && dec_dest != 5'd0;
    run  = m_on && !m_init && !m_err;
    e_dr = run && !m_stall && (m_free != 0 || !req);
    e_rr = run && (RD - m_q.size() >= 2);
    acc  = dec_valid && e_dr;
    alloc = acc && req;
    ptry = run && m_q.size() > 0;
    ovf  = ptry && m_free == NF;
    pop  = ptry && !ovf;
    e_ph = pop ? m_q[0] : 0;
    if (m_on) begin
      chk("m_dec_ready", dec_ready, e_dr);
      chk("m_ret_ready", rob_ret_ready, e_rr);
      chk("m_assign", ren_assign_flag, alloc);
      chk("m_commit", ren_commit_flag, pop);
      chk("m_commit_phys", ren_commit_phys, e_ph);
      chk("m_rename_valid", rename_valid, m_rv);
      chk("m_free_count", free_count, m_free);
      chk("m_err", err_overflow, m_err);
    end
    if (reset) begin
      m_on = 1; m_init = 1; m_err = 0; m_stall = 0; m_rv = 0; m_free = NF;
      m_q.delete();
    end else if (m_on) begin
      old_free = m_free;
      m_rv   = acc;
      m_free = m_free - int'(alloc) + int'(pop);
      if (pop) void'(m_q.pop_front());
      if (e_rr) begin
        if (rob_ret_valid[0] && rob_ret_preg[4:0] != 0) m_q.push_back(int'(rob_ret_preg[4:0]));
        if (rob_ret_valid[1] && rob_ret_preg[9:5] != 0) m_q.push_back(int'(rob_ret_preg[9:5]));
      end
      if (ovf) m_err = 1;
      if (m_init) m_init = 0;
      else if (run && !ovf) begin
        if (!m_stall && dec_valid && req && old_free == 0) m_stall = 1;
        else if (m_stall && old_free != 0) m_stall = 0;
      end
    end
  end

  task automatic set_dec(bit v, bit w, logic [4:0] d);
    dec_valid = v; dec_wr = w; dec_dest = d;
  endtask
  task automatic set_ret(logic [1:0] v, logic [4:0] p1, logic [4:0] p0);
    rob_ret_valid = v; rob_ret_preg = {p1, p0};
  endtask
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    // first cycle after reset: nothing is accepted
    set_dec(1, 1, 5);
    @(negedge clk);
    chk("init_dec_ready", dec_ready, 0);
    chk("init_free", free_count, 31);
    chk("init_ret_ready", rob_ret_ready, 0);
    chk("init_err", err_overflow, 0);
    nxt();
    // drain the free list
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      chk("drain_ready", dec_ready, 1);
      chk("drain_assign", ren_assign_flag, 1);
      chk("drain_free", free_count, 31 - i);
      if (i > 0) chk("drain_rv", rename_valid, 1);
      nxt();
    end
    // dest 0 is accepted even with no free registers
    set_dec(1, 1, 0);
    @(negedge clk);
    chk("x0_ready", dec_ready, 1);
    chk("x0_assign", ren_assign_flag, 0);
    chk("x0_free", free_count, 0);
    nxt();
    set_dec(1, 1, 5);
    @(negedge clk);
    chk("x0_rv", rename_valid, 1);
    chk("full_ready", dec_ready, 0);
    nxt();
    set_dec(0, 0, 0);
    set_ret(2'b01, 0, 7);
    @(negedge clk);
    chk("stall_ready", dec_ready, 0);
    chk("stall_ret_ready", rob_ret_ready, 1);
    nxt();
    set_ret(0, 0, 0);
    set_dec(0, 1, 5);
    @(negedge clk);
    chk("ret7_commit", ren_commit_flag, 1);
    chk("ret7_phys", ren_commit_phys, 7);
    chk("ret7_free_before", free_count, 0);
    nxt();
    @(negedge clk);
    chk("ret7_free", free_count, 1);
    nxt();
    @(negedge clk);
    chk("unstall_ready", dec_ready, 1);
    nxt();
    // three cycles of two-lane returns {3,9}
    set_dec(0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      if (c < 3) set_ret(2'b11, 9, 3); else set_ret(0, 0, 0);
      @(negedge clk);
      if (c == 0) chk("fifo_ready0", rob_ret_ready, 1);
      if (c == 1) chk("fifo_ready1", rob_ret_ready, 1);
      if (c == 2) chk("fifo_ready2", rob_ret_ready, 0);
      chk("fifo_commit", ren_commit_flag, (c >= 1 && c <= 4) ? 1 : 0);
      if (c >= 1 && c <= 4) chk("fifo_phys", ren_commit_phys, (c % 2 == 1) ? 3 : 9);
      nxt();
    end
    @(negedge clk);
    chk("fifo_free", free_count, 5);
    // lane1 zero is dropped
    set_ret(2'b11, 0, 4);
    nxt();
    set_ret(0, 0, 0);
    @(negedge clk);
    chk("drop_phys", ren_commit_phys, 4);
    nxt();
    @(negedge clk);
    chk("drop_commit", ren_commit_flag, 0);
    chk("drop_free", free_count, 6);
    nxt();
    // randomized traffic, occasional reset
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      set_dec($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8, 5'($urandom_range(0, 31)));
      set_ret(2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      nxt();
    end
    // overflow: a return with the free list already full
    reset = 1'b1;
    set_dec(0, 0, 0);
    set_ret(0, 0, 0);
    nxt();
    reset = 1'b0;
    nxt();
    set_ret(2'b01, 0, 12);
    @(negedge clk);
    chk("ovf_ret_ready", rob_ret_ready, 1);
    nxt();
    set_ret(0, 0, 0);
    @(negedge clk);
    chk("ovf_no_commit", ren_commit_flag, 0);
    nxt();
    set_dec(1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ovf_err", err_overflow, 1);
      chk("ovf_dec_ready", dec_ready, 0);
      chk("ovf_ret_ready_lo", rob_ret_ready, 0);
      nxt();
    end
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", err_overflow, 0);
    nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
